// File: rtl/physics_scheduler.sv
// Frame-rate scheduler that time-shares one physics unit across N_OBJ sprites,
// applies clamped motion and owns the sprite position register file.
module physics_scheduler #(
    parameter int N_OBJ    = 4,
    parameter int W        = 21,
    parameter int OBJ_SIZE = 32,
    parameter int INIT_X   = 64,
    parameter int INIT_Y   = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic [N_OBJ-1:0]         enable,
    input  logic signed [W-1:0]      Left_X,
    input  logic signed [W-1:0]      Right_X,
    input  logic signed [W-1:0]      Ceiling_Y,
    input  logic signed [W-1:0]      Ground_Y,
    output logic                     pu_req,
    output logic [$clog2(N_OBJ)-1:0] pu_idx,
    output logic signed [W-1:0]      pu_x,
    output logic signed [W-1:0]      pu_y,
    input  logic                     pu_ack,
    input  logic signed [W-1:0]      pu_dx,
    input  logic signed [W-1:0]      pu_dy,
    output logic [N_OBJ*W-1:0]       obj_x,
    output logic [N_OBJ*W-1:0]       obj_y,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               overrun_cnt,
    output logic [7:0]               timeout_cnt
);

    localparam int IW = $clog2(N_OBJ);
    localparam int CW = $clog2(N_OBJ + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [W+1:0] SIZE_E = (W+2)'(OBJ_SIZE);

    typedef enum logic [2:0] {IDLE, SCAN, REQ, APPLY, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       idx;
    logic [TW-1:0]       wait_cnt;
    logic signed [W-1:0] pos_x [N_OBJ];
    logic signed [W-1:0] pos_y [N_OBJ];
    logic signed [W-1:0] dx_p0;
    logic signed [W-1:0] dy_p0;
    logic signed [W-1:0] cur_x;
    logic signed [W-1:0] cur_y;
    logic signed [W-1:0] nx;
    logic signed [W-1:0] ny;
    logic                en_cur;

    function automatic logic signed [W+1:0] sext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Two guard bits keep pos+delta+OBJ_SIZE free of wrap-around; upper clamp
    // first so the lower bound wins when the playfield is narrower than a sprite.
    function automatic logic signed [W-1:0] clamp_axis(
        input logic signed [W-1:0] pos,
        input logic signed [W-1:0] delta,
        input logic signed [W-1:0] lo,
        input logic signed [W-1:0] hi
    );
        logic signed [W+1:0] n;
        n = sext(pos) + sext(delta);
        if (n + SIZE_E > sext(hi))
            n = sext(hi) - SIZE_E;
        if (n < sext(lo))
            n = sext(lo);
        return n[W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic signed [W-1:0] init_x(input int i);
        return W'(INIT_X + 2 * OBJ_SIZE * i);
    endfunction

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (idx == CW'(i)) begin
                cur_x = pos_x[i];
                cur_y = pos_y[i];
            end
        end
    end

    assign en_cur = |(enable & (N_OBJ'(1) << idx));
    assign nx     = clamp_axis(cur_x, dx_p0, Left_X, Right_X);
    assign ny     = clamp_axis(cur_y, dy_p0, Ceiling_Y, Ground_Y);

    assign pu_req     = (state == REQ);
    assign pu_idx     = idx[IW-1:0];
    assign pu_x       = cur_x;
    assign pu_y       = cur_y;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    for (genvar g = 0; g < N_OBJ; g++) begin : g_flat
        assign obj_x[g*W +: W] = pos_x[g];
        assign obj_y[g*W +: W] = pos_y[g];
    end

    // Motion latch: the value captured on the final REQ cycle is what APPLY uses.
    always_ff @(posedge Clk) begin
        if (state == REQ) begin
            dx_p0 <= pu_ack ? pu_dx : '0;
            dy_p0 <= pu_ack ? pu_dy : '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            overrun_cnt <= '0;
            timeout_cnt <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                pos_x[i] <= init_x(i);
                pos_y[i] <= W'(INIT_Y);
            end
        end else begin
            if (frame_tick && state != IDLE)
                overrun_cnt <= sat_inc(overrun_cnt);
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == CW'(N_OBJ)) begin
                        state <= DONE;
                    end else if (en_cur) begin
                        wait_cnt <= '0;
                        state    <= REQ;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                REQ: begin
                    if (pu_ack) begin
                        state <= APPLY;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                        state       <= APPLY;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                APPLY: begin
                    for (int i = 0; i < N_OBJ; i++) begin
                        if (idx == CW'(i)) begin
                            pos_x[i] <= nx;
                            pos_y[i] <= ny;
                        end
                    end
                    idx   <= idx + CW'(1);
                    state <= SCAN;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
